// File: rtl/t_cnt_using_d_ff_pkg.sv
// -----------------------------------------------------------------------------
// tff_pkg
// Shared definitions for the T-cell counter family: the 2-bit op encoding
// used by t_cnt_using_d_ff and any sequencer block that drives it.
// -----------------------------------------------------------------------------
package tff_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_HOLD   = 2'b00;
  localparam op_t OP_COUNT  = 2'b01;
  localparam op_t OP_LOAD   = 2'b10;
  localparam op_t OP_TOGGLE = 2'b11;

endpackage : tff_pkg

// File: rtl/t_ff_using_d.sv
// -----------------------------------------------------------------------------
// t_ff_using_d
// One T flip-flop cell built from a single D flop whose input is t ^ q.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   rst_val in   value q takes on a reset edge
//   t       in   toggle enable: q flips on the next edge when 1
//   q       out  registered cell state
//   qbar    out  ~q
// -----------------------------------------------------------------------------
module t_ff_using_d (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= rst_val;
    end else begin
      r_q <= t ^ r_q;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule : t_ff_using_d

// File: rtl/t_cnt_using_d_ff.sv
// -----------------------------------------------------------------------------
// t_cnt_using_d_ff
// WIDTH-bit register of T cells (D flop + XOR feedback) chained into a
// synchronous up/down counter with parallel load and per-bit toggle.
// Every state change, including LOAD, is expressed as a toggle vector t.
//
// Interface: no handshake. One op is accepted on every rising edge and its
// effect is visible on q after that edge. up_dn, load_val and tog_mask are
// only looked at when their op is selected.
//
// Parameters:
//   WIDTH    number of cells (2..16)
//   RST_VAL  value of q after a reset edge
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset, overrides every op
//   op        in   00 HOLD, 01 COUNT, 10 LOAD, 11 TOGGLE
//   up_dn     in   COUNT direction: 1 up, 0 down
//   load_val  in   value written by LOAD
//   tog_mask  in   bits flipped by TOGGLE
//   q         out  registered counter value
//   qbar      out  ~q
//   tc        out  combinational terminal count: COUNT and q at the wrap
//                  point for the current direction (usable as the t input
//                  of a cascaded stage)
//
// Build option:
//   TCNT_SAT_EN  when defined, COUNT saturates at the limit instead of
//                wrapping (tc stays high while held there).
// -----------------------------------------------------------------------------
module t_cnt_using_d_ff
  import tff_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  op_t              op,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] tog_mask,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_up_t;   // toggle vector for counting up
  logic [WIDTH-1:0] w_dn_t;   // toggle vector for counting down
  logic [WIDTH-1:0] w_t;      // toggle vector applied to the cells
  logic             w_tc;

  // Bit i toggles when every lower bit is at its carry (up) or borrow
  // (down) value; bit 0 always toggles while counting.
  assign w_up_t[0] = 1'b1;
  assign w_dn_t[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign w_up_t[gi] = &w_q[gi-1:0];
      assign w_dn_t[gi] = &(~w_q[gi-1:0]);
    end
  endgenerate

  assign w_tc = (op == OP_COUNT) && (up_dn ? (&w_q) : (~|w_q));

  always_comb begin
    w_t = '0;
    case (op)
      OP_COUNT: begin
        w_t = up_dn ? w_up_t : w_dn_t;
`ifdef TCNT_SAT_EN
        // At the limit the next count would wrap; freeze instead.
        if (w_tc) begin
          w_t = '0;
        end
`endif
      end
      // Toggle exactly the bits that differ, so q lands on load_val.
      OP_LOAD:   w_t = load_val ^ w_q;
      OP_TOGGLE: w_t = tog_mask;
      default:   w_t = '0;
    endcase
  end

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      t_ff_using_d u_cell (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RST_VAL[gi]),
        .t       (w_t[gi]),
        .q       (w_q[gi]),
        .qbar    (w_qbar[gi])
      );
    end
  endgenerate

  assign q    = w_q;
  assign qbar = w_qbar;
  assign tc   = w_tc;

endmodule : t_cnt_using_d_ff

// File: tb/tb_t_cnt_using_d_ff.sv
module tb_t_cnt_using_d_ff;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   op;
  logic         up_dn;
  logic [W-1:0] load_val;
  logic [W-1:0] tog_mask;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;

  int checks;
  int errors;

  localparam logic [1:0] C_HOLD   = 2'b00;
  localparam logic [1:0] C_COUNT  = 2'b01;
  localparam logic [1:0] C_LOAD   = 2'b10;
  localparam logic [1:0] C_TOGGLE = 2'b11;

  t_cnt_using_d_ff #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .up_dn    (up_dn),
    .load_val (load_val),
    .tog_mask (tog_mask),
    .q        (q),
    .qbar     (qbar),
    .tc       (tc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = C_COUNT; up_dn = 1'b1;
    load_val = 4'hA; tog_mask = 4'hF;
    tick();
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b exp %b", q, 4'b0000); end
    checks++;
    if (qbar !== 4'b1111) begin errors++; $display("FAIL reset_qbar got %b exp %b", qbar, 4'b1111); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (q !== 4'b0000) begin errors++; $display("FAIL reset_held_q cyc %0d got %b exp %b", k, q, 4'b0000); end
    end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [W-1:0] exp_q;
    logic         exp_tc;
    exp_q = 4'b0000;
    op = C_COUNT; up_dn = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      exp_tc = (exp_q == 4'b1111);
      checks++;
      if (tc !== exp_tc) begin errors++; $display("FAIL up_tc step %0d got %b exp %b", k, tc, exp_tc); end
      tick();
      exp_q = exp_q + 4'd1;
      checks++;
      if (q !== exp_q) begin errors++; $display("FAIL up_q step %0d got %b exp %b", k, q, exp_q); end
    end
  endtask

  task automatic test_load_down();
    logic [W-1:0] exp_seq [7];
    logic         exp_tc;
    exp_seq = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    op = C_LOAD; load_val = 4'b0101; up_dn = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL load_tc got %b exp 0", tc); end
    tick();
    checks++;
    if (q !== 4'b0101) begin errors++; $display("FAIL load_q got %b exp %b", q, 4'b0101); end
    op = C_COUNT; up_dn = 1'b0; load_val = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      #1;
      exp_tc = (k == 5);  // q is 0000 before the sixth down edge
      checks++;
      if (tc !== exp_tc) begin errors++; $display("FAIL down_tc step %0d got %b exp %b", k, tc, exp_tc); end
      tick();
      checks++;
      if (q !== exp_seq[k]) begin errors++; $display("FAIL down_q step %0d got %b exp %b", k, q, exp_seq[k]); end
    end
  endtask

  task automatic test_toggle_hold();
    op = C_LOAD; load_val = 4'b1010;
    tick();
    op = C_TOGGLE; tog_mask = 4'b0110; load_val = 4'b0000; up_dn = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL toggle_tc got %b exp 0", tc); end
    tick();
    checks++;
    if (q !== 4'b1100) begin errors++; $display("FAIL toggle_q got %b exp %b", q, 4'b1100); end
    op = C_HOLD;
    for (int k = 0; k < 3; k++) begin
      load_val = W'($urandom_range(0, 15));
      tog_mask = W'($urandom_range(0, 15));
      up_dn    = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL hold_tc cyc %0d got %b exp 0", k, tc); end
      tick();
      checks++;
      if (q !== 4'b1100) begin errors++; $display("FAIL hold_q cyc %0d got %b exp %b", k, q, 4'b1100); end
      checks++;
      if (qbar !== 4'b0011) begin errors++; $display("FAIL hold_qbar cyc %0d got %b exp %b", k, qbar, 4'b0011); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_q;
    op = C_LOAD; load_val = 4'b0111;
    tick();
    op = C_COUNT; up_dn = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL midrst_q got %b exp %b", q, 4'b0000); end
    rst = 1'b0;
    exp_q = 4'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_q = exp_q + 4'd1;
      checks++;
      if (q !== exp_q) begin errors++; $display("FAIL resume_q step %0d got %b exp %b", k, q, exp_q); end
    end
  endtask

  task automatic test_dir_change();
    logic [W-1:0] exp_seq [4];
    logic         dir_seq [4];
    exp_seq = '{4'd4, 4'd3, 4'd2, 4'd3};
    dir_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
    op = C_LOAD; load_val = 4'b0011;
    tick();
    op = C_COUNT;
    for (int k = 0; k < 4; k++) begin
      up_dn = dir_seq[k];
      tick();
      checks++;
      if (q !== exp_seq[k]) begin errors++; $display("FAIL dirchg_q step %0d got %b exp %b", k, q, exp_seq[k]); end
    end
    // tc depends on direction: all-ones is a wrap point only going up
    op = C_LOAD; load_val = 4'b1111;
    tick();
    op = C_COUNT; up_dn = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL tc_ones_down got %b exp 0", tc); end
    up_dn = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL tc_ones_up got %b exp 1", tc); end
    op = C_HOLD;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL tc_ones_hold got %b exp 0", tc); end
    tick();
  endtask

`ifdef TCNT_SAT_EN
  task automatic test_limits();
    op = C_LOAD; load_val = 4'b1110;
    tick();
    op = C_COUNT; up_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (q !== 4'b1111) begin errors++; $display("FAIL sat_up_q step %0d got %b exp %b", k, q, 4'b1111); end
      checks++;
      if (tc !== 1'b1) begin errors++; $display("FAIL sat_up_tc step %0d got %b exp 1", k, tc); end
    end
    op = C_LOAD; load_val = 4'b0000;
    tick();
    op = C_COUNT; up_dn = 1'b0;
    tick();
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL sat_dn_q got %b exp %b", q, 4'b0000); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL sat_dn_tc got %b exp 1", tc); end
    op = C_TOGGLE; tog_mask = 4'b0001;
    tick();
    checks++;
    if (q !== 4'b0001) begin errors++; $display("FAIL sat_toggle_off got %b exp %b", q, 4'b0001); end
  endtask
`else
  task automatic test_limits();
    op = C_LOAD; load_val = 4'b1111;
    tick();
    op = C_COUNT; up_dn = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL wrap_up_q got %b exp %b", q, 4'b0000); end
    up_dn = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL wrap_dn_tc got %b exp 1", tc); end
    tick();
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL wrap_dn_q got %b exp %b", q, 4'b1111); end
    checks++;
    if (qbar !== 4'b0000) begin errors++; $display("FAIL wrap_dn_qbar got %b exp %b", qbar, 4'b0000); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; op = C_HOLD; up_dn = 1'b0;
    load_val = '0; tog_mask = '0;
    @(negedge clk);
    test_reset();
    test_count_up();
    test_load_down();
    test_toggle_hold();
    test_reset_mid();
    test_dir_change();
    test_limits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_t_cnt_using_d_ff
